arb_mux_nto1: RTL and testbench
===============================

# arb_mux_nto1

Parametrised, registered N-to-1 multiplexer with round-robin arbitration and a valid/ready handshake on every input channel and on the output. It succeeds the plain 2-to-1 select mux in the datapath wherever several producers share one consumer (write-back ports, memory request merging, forwarding sources that stall). Selection is made by the block itself, not by an external select line. Each granted beat passes through one output register stage.

## Interface
- `size`, default 32: data width per channel in bits.
- `num`, default 4: channel count; legal values are num >= 2.
- `SW`, derived as $clog2(num): width of the index outputs.

- `clk_i`  in  1: clock; all state changes on its rising edge.
- `rst_i`  in  1: reset, asynchronous and active-low.
- `data_i`  in  num*size: channel k occupies bits [k*size +: size].
- `valid_i`  in  num: per-channel request.
- `ready_o`  out  num: per-channel accept; combinational.
- `last_i`  in  num: per-channel end-of-packet flag. Present only with `ARB_MUX_LOCK_EN`.
- `data_o`  out  size: registered selected data.
- `valid_o`  out  1: output register holds a beat.
- `ready_i`  in  1: downstream accepts the beat.
- `sel_o`  out  SW: registered index of the channel whose beat is in `data_o`.

## Operation
- Load enable: `ld = !valid_o || ready_i`.
- Grant: one-hot over channels with valid_i=1, searched round-robin from `ptr+1` modulo num, where `ptr` is the last granted index. If no channel is valid, there is no grant.
- `ready_o[k] = ld && grant[k]`. At most one bit of `ready_o` is high, and `ready_o[k]` is never high while `valid_i[k]` is 0.
- Transfer on channel g (valid_i[g] && ready_o[g]) at a clock edge:
  - `data_o` <= data_i[g]
  - `sel_o` <= g
  - `valid_o` <= 1
  - `ptr` <= g
- If `ld` is high and there is no grant: `valid_o` <= 0. `data_o`, `sel_o` and `ptr` hold.
- If `ld` is low: all state holds. This is a stall.
- Reset values (asserted asynchronously while rst_i=0):
  - `valid_o` = 0, `data_o` = 0, `sel_o` = 0
  - `ptr` = num-1, so channel 0 has first priority after reset
  - lock flag = 0
  - `ready_o` = 0, because `ld` is high but no grant is made while in reset
- Reset released mid-packet: the lock is lost and in-flight output data is discarded. Upstream must restart its packets.
- Channel k with valid_i[k] held high waits at most num-1 other grants before it is granted (without lock).

## Timing
- Latency is 1 cycle: a beat accepted at edge n appears on `data_o`/`valid_o` after edge n.
- Throughput is 1 beat per cycle while `ready_i` is held high. The pass-through case (valid_o && ready_i) reloads in the same edge with no bubble.
- Upstream rule: once valid_i[k] is raised, it holds with data_i[k] stable until ready_o[k]. Downstream sees the same rule on valid_o/data_o.
- Combinational paths exist from ready_i and valid_i to ready_o. There are no combinational paths from any input to data_o, valid_o or sel_o.
- Simultaneous pop and push: the output register is overwritten at that edge. The beat is neither lost nor duplicated.

## Configuration
- `ARB_MUX_LOCK_EN` defined:
  - The `last_i` port exists.
  - Accepting a beat with last_i[g]=0 sets the lock flag, and grant is then forced to `ptr` only.
  - While locked, other channels see ready_o=0 even if valid_i[ptr] is 0; the cycle becomes an idle bubble.
  - The lock clears when a beat with last_i[ptr]=1 is accepted. A single-beat packet (last=1) never locks.
- `ARB_MUX_LOCK_EN` undefined:
  - No `last_i` port and no lock flag.
  - Arbitration happens every beat.

## Test plan
- Reset, then raise all valid_i with ready_i=1 (num=4, channel k data = 0xA0+k) -> grants 0,1,2,3,0 on consecutive edges; `sel_o` sequence 0,1,2,3,0; valid_o is high from the 2nd cycle on.
- Only channel 2 valid with data 0x55, ready_i=0 -> one transfer, then `ready_o`=0; data_o=0x55 and sel_o=2 hold until ready_i=1.
- Back-pressure while valid_o=1 and channels 1 and 3 are valid: ready_i=0 for 5 cycles -> no ready_o pulse and outputs stable. When ready_i rises: ch1 accepted on that edge, then ch3 on the next.
- With the lock enabled: ch0 sends 3 beats (last=0,0,1) while ch1 is valid throughout -> ch1 gets ready_o only after ch0's last beat. A 1-cycle gap in ch0 valid mid-packet -> a bubble, not a ch1 grant.
- rst_i pulsed low mid-stream -> valid_o, data_o and sel_o go to 0 immediately, without waiting for a clock. After release, the first grant is to the lowest valid channel.
- num=2, size=8 build -> behaves as a handshaked 2-to-1 mux that alternates grants when both channels are valid.

Source files
------------

// File: rtl/arb_mux_nto1_if.sv
// rtl/arb_mux_nto1_if.sv - channel and output handshake bundle for arb_mux_nto1
// last_i exists only when ARB_MUX_LOCK_EN is defined.
interface arb_mux_nto1_if #(
    parameter int size = 32,
    parameter int num  = 4
);
    localparam int SW = $clog2(num);

    logic [num*size-1:0] data_i;
    logic [num-1:0]      valid_i;
    logic [num-1:0]      ready_o;
`ifdef ARB_MUX_LOCK_EN
    logic [num-1:0]      last_i;
`endif
    logic [size-1:0]     data_o;
    logic                valid_o;
    logic                ready_i;
    logic [SW-1:0]       sel_o;

`ifdef ARB_MUX_LOCK_EN
    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, sel_o
    );
    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, sel_o
    );
`else
    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, sel_o
    );
    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, sel_o
    );
`endif
endinterface

// File: rtl/arb_mux_nto1.sv
// rtl/arb_mux_nto1.sv - registered N-to-1 round-robin arbitrating mux with valid/ready
// Optional packet lock (hold grant until last_i) with ARB_MUX_LOCK_EN.
module arb_mux_nto1 #(
    parameter int size = 32,
    parameter int num  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    arb_mux_nto1_if.slave bus
);
    localparam int SW = $clog2(num);

    logic            ld;
    logic            gnt_any;
    logic [SW-1:0]   gnt_idx;
    logic [size-1:0] gnt_data;
    logic [SW-1:0]   cand;
    int              j;

    logic [SW-1:0]   ptr_q;
    logic [SW-1:0]   sel_q;
    logic [size-1:0] data_q;
    logic            valid_q;
`ifdef ARB_MUX_LOCK_EN
    logic            lock_q;
    logic            gnt_last;
`endif

    assign ld = !valid_q || bus.ready_i;

    // Search starts one past the last winner so every waiting channel gets a turn.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = '0;
        j       = 0;
        for (int i = 1; i <= num; i++) begin
            j = int'(ptr_q) + i;
            if (j >= num) begin
                j = j - num;
            end
            cand = SW'(j);
            if (!gnt_any && bus.valid_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
`ifdef ARB_MUX_LOCK_EN
        if (lock_q) begin
            gnt_any = bus.valid_i[ptr_q];
            gnt_idx = ptr_q;
        end
`endif
        if (!rst_i) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < num; k++) begin
            if (gnt_idx == SW'(k)) begin
                gnt_data = bus.data_i[k*size +: size];
            end
        end
    end

`ifdef ARB_MUX_LOCK_EN
    assign gnt_last = bus.last_i[gnt_idx];
`endif

    always_comb begin
        bus.ready_o = '0;
        for (int k = 0; k < num; k++) begin
            bus.ready_o[k] = ld && gnt_any && (gnt_idx == SW'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= SW'(num - 1);
`ifdef ARB_MUX_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else if (ld) begin
            if (gnt_any) begin
                valid_q <= 1'b1;
                data_q  <= gnt_data;
                sel_q   <= gnt_idx;
                ptr_q   <= gnt_idx;
`ifdef ARB_MUX_LOCK_EN
                lock_q  <= !gnt_last;
`endif
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.sel_o   = sel_q;
endmodule

// File: tb/tb_arb_mux_nto1.sv
// tb/tb_arb_mux_nto1.sv - directed and randomized checks of arb_mux_nto1 against a reference model
module tb_arb_mux_nto1;
    localparam int NUM  = 4;
    localparam int SIZE = 32;

    logic clk   = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    arb_mux_nto1_if #(.size(SIZE), .num(NUM)) bus ();
    arb_mux_nto1_if #(.size(8), .num(2))      bus2 ();

    arb_mux_nto1 #(.size(SIZE), .num(NUM)) dut  (.clk_i(clk), .rst_i(rst_i), .bus(bus.slave));
    arb_mux_nto1 #(.size(8), .num(2))      dut2 (.clk_i(clk), .rst_i(rst_i), .bus(bus2.slave));

    int checks = 0;
    int passed = 0;

    bit              m_valid;
    logic [SIZE-1:0] m_data;
    int              m_sel;
    int              m_ptr;
    bit              m_lock;
    logic [NUM-1:0]  last_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_sel    = 0;
        m_ptr    = NUM - 1;
        m_lock   = 1'b0;
        last_acc = '0;
    endtask

    // Winner among currently valid channels, -1 when none.
    function automatic int pick();
        int c;
        if (m_lock) return bus.valid_i[m_ptr] ? m_ptr : -1;
        for (int i = 1; i <= NUM; i++) begin
            c = (m_ptr + i) % NUM;
            if (bus.valid_i[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_ch(input int k, input bit v, input logic [SIZE-1:0] d, input bit l);
        bus.valid_i[k]            = v;
        bus.data_i[k*SIZE +: SIZE] = d;
`ifdef ARB_MUX_LOCK_EN
        bus.last_i[k]             = l;
`else
        if (l) begin end
`endif
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle();
        int              g;
        bit              ld;
        bit              gl;
        logic [NUM-1:0]  exp_ready;
        logic [SIZE-1:0] gd;
        #1;
        ld = !m_valid || bus.ready_i;
        g  = ld ? pick() : -1;
        exp_ready = '0;
        gd = '0;
        gl = 1'b1;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            gd = bus.data_i[g*SIZE +: SIZE];
`ifdef ARB_MUX_LOCK_EN
            gl = bus.last_i[g];
`endif
        end
        chk("ready_o", bus.ready_o, exp_ready);
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = gd;
                m_sel   = g;
                m_ptr   = g;
`ifdef ARB_MUX_LOCK_EN
                m_lock  = !gl;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        last_acc = exp_ready;
        #1;
        chk("valid_o", bus.valid_o, m_valid);
        chk("data_o", bus.data_o, m_data);
        chk("sel_o", bus.sel_o, m_sel);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < NUM; k++) set_ch(k, 1'b1, SIZE'(32'hA0 + k), 1'b1);
        bus.ready_i  = 1'b1;
        bus2.valid_i = '0;
        bus2.data_i  = '0;
        bus2.ready_i = 1'b1;
`ifdef ARB_MUX_LOCK_EN
        bus2.last_i  = '1;
`endif
        model_reset();

        #1;
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_data", bus.data_o, 0);
        chk("rst_sel", bus.sel_o, 0);
        chk("rst_ready", bus.ready_o, 0);
        repeat (2) @(negedge clk);
        chk("rst_ready_clk", bus.ready_o, 0);
        chk("rst_valid_clk", bus.valid_o, 0);

        // All channels valid: plain rotation starting at channel 0.
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_sel", bus.sel_o, i % NUM);
        end

        // Single channel 2 beat held under back-pressure.
        for (int k = 0; k < NUM; k++) set_ch(k, 1'b0, '0, 1'b1);
        cycle();
        set_ch(2, 1'b1, 32'h55, 1'b1);
        bus.ready_i = 1'b0;
        cycle();
        set_ch(2, 1'b0, '0, 1'b1);
        repeat (3) cycle();
        chk("hold_data", bus.data_o, 32'h55);
        chk("hold_sel", bus.sel_o, 2);

        // Pop and push on the same edge, then stall with channels 1 and 3 waiting.
        bus.ready_i = 1'b1;
        set_ch(3, 1'b1, 32'h33, 1'b1);
        cycle();
        bus.ready_i = 1'b0;
        set_ch(1, 1'b1, 32'h11, 1'b1);
        set_ch(3, 1'b1, 32'h34, 1'b1);
        repeat (5) cycle();
        chk("bp_data", bus.data_o, 32'h33);
        bus.ready_i = 1'b1;
        cycle();
        chk("bp_first", bus.sel_o, 1);
        set_ch(1, 1'b0, '0, 1'b1);
        cycle();
        chk("bp_second", bus.sel_o, 3);
        chk("bp_second_data", bus.data_o, 32'h34);
        set_ch(3, 1'b0, '0, 1'b1);
        cycle();

`ifdef ARB_MUX_LOCK_EN
        // Three-beat packet on ch0 with a gap; ch1 must wait for the last beat.
        set_ch(0, 1'b1, 32'hB0, 1'b0);
        set_ch(1, 1'b1, 32'hC1, 1'b1);
        cycle();
        chk("lock_b0", bus.sel_o, 0);
        set_ch(0, 1'b1, 32'hB1, 1'b0);
        cycle();
        chk("lock_b1", bus.sel_o, 0);
        set_ch(0, 1'b0, '0, 1'b0);
        cycle();
        chk("lock_bubble", bus.valid_o, 0);
        set_ch(0, 1'b1, 32'hB2, 1'b1);
        cycle();
        chk("lock_b2", bus.data_o, 32'hB2);
        set_ch(0, 1'b0, '0, 1'b1);
        cycle();
        chk("lock_release", bus.sel_o, 1);
        set_ch(1, 1'b0, '0, 1'b1);
        cycle();
`endif

        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM; k++) begin
                if (!bus.valid_i[k] || last_acc[k])
                    set_ch(k, $urandom_range(0, 3) != 0, SIZE'($urandom), $urandom_range(0, 2) == 0);
            end
            bus.ready_i = $urandom_range(0, 3) != 0;
            cycle();
        end

        // Asynchronous reset mid-stream.
        bus.ready_i = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_valid", bus.valid_o, 0);
        chk("arst_data", bus.data_o, 0);
        chk("arst_sel", bus.sel_o, 0);
        chk("arst_ready", bus.ready_o, 0);
        model_reset();
        @(negedge clk);
        chk("arst_hold", bus.valid_o, 0);
        set_ch(0, 1'b0, '0, 1'b1);
        set_ch(1, 1'b1, 32'hD1, 1'b1);
        set_ch(2, 1'b1, 32'hD2, 1'b1);
        set_ch(3, 1'b0, '0, 1'b1);
        bus.ready_i = 1'b1;
        rst_i = 1'b1;
        cycle();
        chk("arst_first", bus.sel_o, 1);
        for (int k = 0; k < NUM; k++) set_ch(k, 1'b0, '0, 1'b1);
        repeat (2) cycle();

        // Two-channel build alternates when both channels are valid.
        bus2.data_i  = {8'h22, 8'h11};
        bus2.valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mux2_ready", bus2.ready_o, (i % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
            chk("mux2_sel", bus2.sel_o, i % 2);
            chk("mux2_data", bus2.data_o, (i % 2 == 1) ? 8'h22 : 8'h11);
            chk("mux2_valid", bus2.valid_o, 1);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
